// File: rtl/qspi_sampler.sv
// rtl/qspi_sampler.sv - oversampled single/dual/quad SPI slave front end; optional dummy phase under QSPI_DUMMY_EN
module qspi_sampler #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DUAL_CMD    = 8'h3B,
  parameter logic [7:0] QUAD_CMD    = 8'hEB,
  parameter int         ADDR_BYTES  = 3,
  parameter int         DUMMY_CLKS  = 4,
  parameter int         COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               spi_clk,
  input  logic               spi_cs,
  input  logic [3:0]         spi_data_in,
  output logic [3:0]         spi_data_out,
  output logic [3:0]         spi_data_oe,
  input  logic [7:0]         tx_byte,
  input  logic               tx_load,
  output logic [7:0]         byte_rx,
  output logic               cmd_strobe,
  output logic               byte_strobe,
  output logic               abort_strobe,
  output logic [1:0]         lane_mode,
  output logic [COUNT_W-1:0] byte_count
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
`ifdef QSPI_DUMMY_EN
    ST_DUMMY = 3'd3,
`endif
    ST_DATA  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [5:0]         sync_q [SYNC_STAGES];
  logic [1:0]         edge_q;
  logic [3:0]         bit_cnt_q;
  logic [7:0]         rx_sr_q;
  logic [7:0]         tx_sr_q;
  logic [7:0]         tx_hold_q;
  logic               tx_first_q;
  logic [7:0]         addr_cnt_q;
  logic [7:0]         byte_rx_q;
  logic               cmd_strobe_q;
  logic               byte_strobe_q;
  logic               abort_strobe_q;
  logic [1:0]         lane_mode_q;
  logic [COUNT_W-1:0] byte_count_q;

  logic       cs_s, sclk_s, cs_fall, sclk_rise, sclk_fall;
  logic [3:0] din_s;
  logic [7:0] rx_shift, tx_shift;
  logic [3:0] lane_bits, bits_next;
  logic       byte_done, receiving, rx_rise, cs_leave, complete, abort, is_multi, addr_last;
  logic       dummy_done;

  // Synchronize {cs, clk, data} and keep one more copy of cs/clk for edge detection.
  // Chain resets low so a CS already low at reset release is not seen as a falling edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      edge_q <= '0;
    end else begin
      sync_q[0] <= {spi_cs, spi_clk, spi_data_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      edge_q <= sync_q[SYNC_STAGES-1][5:4];
    end
  end

  assign cs_s      = sync_q[SYNC_STAGES-1][5];
  assign sclk_s    = sync_q[SYNC_STAGES-1][4];
  assign din_s     = sync_q[SYNC_STAGES-1][3:0];
  assign sclk_rise = sclk_s & ~edge_q[0];
  assign sclk_fall = ~sclk_s & edge_q[0];
  assign cs_fall   = ~cs_s & edge_q[1];

  // Per-lane-mode shift width; high lane carries the more significant bit.
  always_comb begin
    rx_shift  = {rx_sr_q[6:0], din_s[0]};
    tx_shift  = {tx_sr_q[6:0], 1'b0};
    lane_bits = 4'd1;
    case (lane_mode_q)
      2'd1: begin
        rx_shift  = {rx_sr_q[5:0], din_s[1:0]};
        tx_shift  = {tx_sr_q[5:0], 2'b00};
        lane_bits = 4'd2;
      end
      2'd2: begin
        rx_shift  = {rx_sr_q[3:0], din_s};
        tx_shift  = {tx_sr_q[3:0], 4'b0000};
        lane_bits = 4'd4;
      end
      default: ;
    endcase
  end

  assign bits_next = bit_cnt_q + lane_bits;
  assign byte_done = (bits_next == 4'd8);
  assign receiving = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign rx_rise   = sclk_rise & receiving;
  assign cs_leave  = cs_s & (state_q != ST_IDLE);
  // CS high wins over a byte completing in the same synced cycle.
  assign complete  = rx_rise & byte_done & ~cs_s;
  assign abort     = cs_leave & ((bit_cnt_q != 4'd0) | rx_rise);
  assign is_multi  = (rx_shift == QUAD_CMD) || (rx_shift == DUAL_CMD);
  assign addr_last = complete & (state_q == ST_ADDR) & (addr_cnt_q == 8'(ADDR_BYTES - 1));

`ifdef QSPI_DUMMY_EN
  logic [7:0] dummy_cnt_q;
  assign dummy_done = (state_q == ST_DUMMY) & sclk_rise & ~cs_s &
                      (dummy_cnt_q == 8'(DUMMY_CLKS - 1));

  // Count skipped clocks between the address and the data phase.
  always_ff @(posedge clk) begin
    if (!reset || state_q != ST_DUMMY) dummy_cnt_q <= '0;
    else if (sclk_rise)                dummy_cnt_q <= dummy_cnt_q + 8'd1;
  end
`else
  logic unused_dummy_clks;
  assign unused_dummy_clks = ^DUMMY_CLKS;
  assign dummy_done        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: CS high from any active state returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (cs_leave) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (cs_fall) state_d = ST_CMD;
        ST_CMD:  if (complete) state_d = is_multi ? ST_ADDR : ST_DATA;
`ifdef QSPI_DUMMY_EN
        ST_ADDR:  if (addr_last) state_d = ST_DUMMY;
        ST_DUMMY: if (dummy_done) state_d = ST_DATA;
`else
        ST_ADDR:  if (addr_last) state_d = ST_DATA;
`endif
        default: ;
      endcase
    end
  end

  // Output logic: lane drivers and enables by state and lane mode.
  always_comb begin
    spi_data_oe = 4'b0000;
    case (state_q)
      ST_CMD:  spi_data_oe = 4'b0010;
      ST_DATA: begin
        case (lane_mode_q)
          2'd2:    spi_data_oe = 4'b1111;
          2'd1:    spi_data_oe = 4'b0011;
          default: spi_data_oe = 4'b0010;
        endcase
      end
      default: ;
    endcase
    case (lane_mode_q)
      2'd2:    spi_data_out = tx_sr_q[7:4];
      2'd1:    spi_data_out = {2'b00, tx_sr_q[7:6]};
      default: spi_data_out = {2'b00, tx_sr_q[7], 1'b0};
    endcase
  end

  // Receive/transmit datapath, strobes and byte counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_cnt_q      <= '0;
      rx_sr_q        <= '0;
      tx_sr_q        <= '0;
      tx_hold_q      <= '0;
      tx_first_q     <= 1'b0;
      addr_cnt_q     <= '0;
      byte_rx_q      <= '0;
      cmd_strobe_q   <= 1'b0;
      byte_strobe_q  <= 1'b0;
      abort_strobe_q <= 1'b0;
      lane_mode_q    <= '0;
      byte_count_q   <= '0;
    end else begin
      cmd_strobe_q   <= 1'b0;
      byte_strobe_q  <= 1'b0;
      abort_strobe_q <= abort;
      if (tx_load) tx_hold_q <= tx_byte;
      if (state_q == ST_IDLE) begin
        bit_cnt_q   <= '0;
        addr_cnt_q  <= '0;
        lane_mode_q <= '0;
        if (cs_fall) begin
          byte_count_q <= '0;
          tx_first_q   <= 1'b1;
        end
      end else if (cs_s) begin
        bit_cnt_q <= '0;
      end else begin
        if (rx_rise) begin
          rx_sr_q <= rx_shift;
          if (byte_done) begin
            bit_cnt_q  <= '0;
            byte_rx_q  <= rx_shift;
            tx_first_q <= 1'b1;
            if (byte_count_q != '1) byte_count_q <= byte_count_q + COUNT_W'(1);
            if (state_q == ST_CMD) begin
              cmd_strobe_q <= 1'b1;
              if (rx_shift == QUAD_CMD)      lane_mode_q <= 2'd2;
              else if (rx_shift == DUAL_CMD) lane_mode_q <= 2'd1;
            end else begin
              byte_strobe_q <= 1'b1;
              if (state_q == ST_ADDR) addr_cnt_q <= addr_cnt_q + 8'd1;
            end
          end else begin
            bit_cnt_q <= bits_next;
          end
        end
        if (dummy_done) tx_first_q <= 1'b1;
        if (sclk_fall) begin
          if (tx_first_q) begin
            tx_sr_q    <= tx_load ? tx_byte : tx_hold_q;
            tx_first_q <= 1'b0;
          end else begin
            tx_sr_q <= tx_shift;
          end
        end
      end
    end
  end

  assign byte_rx      = byte_rx_q;
  assign cmd_strobe   = cmd_strobe_q;
  assign byte_strobe  = byte_strobe_q;
  assign abort_strobe = abort_strobe_q;
  assign lane_mode    = lane_mode_q;
  assign byte_count   = byte_count_q;

endmodule

// File: tb/tb_qspi_sampler.sv
// tb/tb_qspi_sampler.sv - scoreboard bench for qspi_sampler at SYNC_STAGES 2 and 3
module tb_qspi_sampler;
  localparam logic [7:0] DUAL_CMD   = 8'h3B;
  localparam logic [7:0] QUAD_CMD   = 8'hEB;
  localparam int         ADDR_BYTES = 3;
  localparam int         DUMMY_CLKS = 4;
`ifdef QSPI_DUMMY_EN
  localparam bit DUMMY_EN = 1'b1;
`else
  localparam bit DUMMY_EN = 1'b0;
`endif
  localparam logic [2:0] K_CMD = 3'b001, K_BYTE = 3'b010, K_ABORT = 3'b100;

  typedef struct { logic [2:0] kind; logic [7:0] val; int cyc; } exp_t;

  logic clk = 1'b0;
  logic reset, spi_clk, spi_cs, tx_load;
  logic [3:0] spi_data_in;
  logic [7:0] tx_byte;
  logic [3:0] out_a, oe_a, out_b, oe_b;
  logic [7:0] rx_a, rx_b;
  logic cmd_a, byte_a, abort_a, cmd_b, byte_b, abort_b;
  logic [1:0] lm_a, lm_b;
  logic [15:0] count_a, count_b;

  int n_checks = 0, n_pass = 0, cyc = 0;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  logic [7:0] pay[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  qspi_sampler #(.SYNC_STAGES(2), .DUAL_CMD(DUAL_CMD), .QUAD_CMD(QUAD_CMD),
                 .ADDR_BYTES(ADDR_BYTES), .DUMMY_CLKS(DUMMY_CLKS), .COUNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_data_in(spi_data_in),
    .spi_data_out(out_a), .spi_data_oe(oe_a), .tx_byte(tx_byte), .tx_load(tx_load),
    .byte_rx(rx_a), .cmd_strobe(cmd_a), .byte_strobe(byte_a), .abort_strobe(abort_a),
    .lane_mode(lm_a), .byte_count(count_a));

  qspi_sampler #(.SYNC_STAGES(3), .DUAL_CMD(DUAL_CMD), .QUAD_CMD(QUAD_CMD),
                 .ADDR_BYTES(ADDR_BYTES), .DUMMY_CLKS(DUMMY_CLKS), .COUNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_data_in(spi_data_in),
    .spi_data_out(out_b), .spi_data_oe(oe_b), .tx_byte(tx_byte), .tx_load(tx_load),
    .byte_rx(rx_b), .cmd_strobe(cmd_b), .byte_strobe(byte_b), .abort_strobe(abort_b),
    .lane_mode(lm_b), .byte_count(count_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard monitors: one per instance, popping on every strobe.
  always @(negedge clk) begin
    if (reset === 1'b1 && (cmd_a | byte_a | abort_a)) begin
      if (qa.size() == 0) begin
        n_checks++;
        $display("FAIL a_unexpected_strobe: got kind %b rx %h expected none", {abort_a, byte_a, cmd_a}, rx_a);
      end else begin
        ea = qa.pop_front();
        chk("a_kind", 32'({abort_a, byte_a, cmd_a}), 32'(ea.kind));
        if (ea.kind != K_ABORT) chk("a_byte_rx", 32'(rx_a), 32'(ea.val));
        chk("a_latency", 32'(cyc - ea.cyc), 32'd3);
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1 && (cmd_b | byte_b | abort_b)) begin
      if (qb.size() == 0) begin
        n_checks++;
        $display("FAIL b_unexpected_strobe: got kind %b rx %h expected none", {abort_b, byte_b, cmd_b}, rx_b);
      end else begin
        eb = qb.pop_front();
        chk("b_kind", 32'({abort_b, byte_b, cmd_b}), 32'(eb.kind));
        if (eb.kind != K_ABORT) chk("b_byte_rx", 32'(rx_b), 32'(eb.val));
        chk("b_latency", 32'(cyc - eb.cyc), 32'd4);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_both(input logic [2:0] kind, input logic [7:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = cyc;
    qa.push_back(e);
    qb.push_back(e);
  endtask

  // Lane values for rise k of a byte carried on l lanes; unused lanes get noise.
  function automatic logic [3:0] lanes_for(input logic [7:0] b, input int l, input int k);
    logic [7:0] sh;
    logic [3:0] r;
    sh = b >> (8 - l * (k + 1));
    r  = 4'($urandom);
    case (l)
      4:       r = sh[3:0];
      2:       r[1:0] = sh[1:0];
      default: r[0] = sh[0];
    endcase
    return r;
  endfunction

  function automatic logic [3:0] tx_expect(input logic [7:0] tx, input int l, input int k);
    logic [7:0] sh;
    sh = tx >> (8 - l * (k + 1));
    case (l)
      4:       return sh[3:0];
      2:       return {2'b00, sh[1:0]};
      default: return {2'b00, sh[0], 1'b0};
    endcase
  endfunction

  task automatic spi_rise(input logic [3:0] d, input logic [3:0] eoe, input bit do_out,
                          input logic [3:0] eout, input bit push, input logic [2:0] kind,
                          input logic [7:0] val);
    chk("oe", 32'(oe_a), 32'(eoe));
    if (do_out) chk("tx_lanes", 32'(out_a & eoe), 32'(eout));
    spi_data_in = d;
    tick(3);
    if (push) expect_both(kind, val);
    spi_clk = 1'b1;
    tick(6);
    spi_clk = 1'b0;
    tick(6);
  endtask

  // One transaction: command, payload bytes from pay[], optional partial byte then CS rise.
  task automatic run_txn(input logic [7:0] cmd, input logic [7:0] tx, input int ab, input bit coincide);
    int l, n_addr, rpb, nb;
    logic [1:0] lm;
    logic [3:0] data_oe, eoe;
    bit is_data;
    l       = (cmd == QUAD_CMD) ? 4 : (cmd == DUAL_CMD) ? 2 : 1;
    lm      = (l == 4) ? 2'd2 : (l == 2) ? 2'd1 : 2'd0;
    data_oe = (l == 4) ? 4'hF : (l == 2) ? 4'h3 : 4'h2;
    n_addr  = (l > 1) ? ADDR_BYTES : 0;
    rpb     = 8 / l;
    tx_byte = tx; tx_load = 1'b1; tick(1);
    tx_load = 1'b0; tx_byte = 8'($urandom);
    spi_cs = 1'b0; tick(8);
    chk("count_clear_a", 32'(count_a), 32'd0);
    chk("count_clear_b", 32'(count_b), 32'd0);
    for (int k = 0; k < 8; k++)
      spi_rise(lanes_for(cmd, 1, k), 4'h2, 1'b0, 4'h0, k == 7, K_CMD, cmd);
    chk("lane_mode_a", 32'(lm_a), 32'(lm));
    chk("lane_mode_b", 32'(lm_b), 32'(lm));
    nb = 1;
    for (int i = 0; i < pay.size(); i++) begin
      if (DUMMY_EN && l > 1 && i == n_addr) begin
        for (int k = 0; k < DUMMY_CLKS; k++)
          spi_rise(4'($urandom), 4'h0, 1'b0, 4'h0, 1'b0, K_BYTE, 8'h00);
        chk("rx_after_dummy", 32'(rx_a), 32'(pay[n_addr-1]));
      end
      is_data = (i >= n_addr);
      eoe = is_data ? data_oe : 4'h0;
      for (int k = 0; k < rpb; k++)
        spi_rise(lanes_for(pay[i], l, k), eoe, is_data, tx_expect(tx, l, k), k == rpb - 1, K_BYTE, pay[i]);
      nb++;
    end
    is_data = (pay.size() >= n_addr);
    eoe = is_data ? data_oe : 4'h0;
    if (ab > 0) begin
      for (int k = 0; k < ab; k++) spi_rise(4'($urandom), eoe, 1'b0, 4'h0, 1'b0, K_BYTE, 8'h00);
      if (coincide) begin
        spi_data_in = 4'($urandom);
        tick(3);
        expect_both(K_ABORT, 8'h00);
        spi_clk = 1'b1; spi_cs = 1'b1;
        tick(6);
        spi_clk = 1'b0;
      end else begin
        expect_both(K_ABORT, 8'h00);
        spi_cs = 1'b1;
      end
    end else begin
      spi_cs = 1'b1;
    end
    tick(10);
    chk("byte_count_a", 32'(count_a), 32'(nb));
    chk("byte_count_b", 32'(count_b), 32'(nb));
    chk("idle_lane_mode", 32'(lm_a), 32'd0);
    chk("idle_oe", 32'(oe_a), 32'd0);
  endtask

  initial begin
    int sel, len, l, n_addr, ab;
    bit co;
    logic [7:0] cmd;
    reset = 1'b0; spi_clk = 1'b0; spi_cs = 1'b1; spi_data_in = 4'h0;
    tx_byte = 8'h00; tx_load = 1'b0;
    tick(4);
    chk("rst_outputs", 32'({cmd_a, byte_a, abort_a, lm_a, oe_a, out_a}), 32'd0);
    chk("rst_rx_count", 32'({rx_a, count_a}), 32'd0);
    chk("rst_outputs_b", 32'({cmd_b, byte_b, abort_b, lm_b, oe_b, rx_b}), 32'd0);
    reset = 1'b1;
    tick(8);

    pay = '{8'hA5, 8'h5A, 8'h01, 8'h02};
    run_txn(8'h03, 8'h96, 0, 1'b0);
    pay = '{8'h10, 8'h20, 8'h30, 8'h40};
    run_txn(QUAD_CMD, 8'hC3, 0, 1'b0);
    pay = '{8'hA5};
    run_txn(DUAL_CMD, 8'h5C, 0, 1'b0);
    pay = '{};
    run_txn(8'h03, 8'h11, 5, 1'b0);
    pay = '{8'h77};
    run_txn(8'h0B, 8'h2D, 0, 1'b0);
    pay = '{8'h81};
    run_txn(8'h03, 8'hE7, 7, 1'b1);
    pay = '{8'h10, 8'h20, 8'h30, 8'h44};
    run_txn(QUAD_CMD, 8'h69, 1, 1'b1);

    // Reset mid-transaction: the rest of this CS-low period must be ignored.
    spi_cs = 1'b0; tick(8);
    for (int k = 0; k < 3; k++) spi_rise(4'($urandom), 4'h2, 1'b0, 4'h0, 1'b0, K_BYTE, 8'h00);
    reset = 1'b0; tick(2);
    reset = 1'b1; tick(2);
    chk("midrst_count", 32'(count_a), 32'd0);
    chk("midrst_lane_mode", 32'(lm_a), 32'd0);
    for (int k = 0; k < 10; k++) spi_rise(4'($urandom), 4'h0, 1'b0, 4'h0, 1'b0, K_BYTE, 8'h00);
    spi_cs = 1'b1; tick(10);
    pay = '{8'h3C, 8'hC3};
    run_txn(8'h9F, 8'hA1, 0, 1'b0);

    for (int t = 0; t < 10; t++) begin
      sel = $urandom_range(0, 3);
      cmd = (sel == 0) ? QUAD_CMD : (sel == 1) ? DUAL_CMD : (sel == 2) ? 8'h03 : 8'($urandom);
      l = (cmd == QUAD_CMD) ? 4 : (cmd == DUAL_CMD) ? 2 : 1;
      n_addr = (l > 1) ? ADDR_BYTES : 0;
      len = $urandom_range(0, 5);
      pay.delete();
      for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
      ab = 0; co = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        ab = $urandom_range(1, 8 / l - 1);
        co = (ab == 8 / l - 1) && ($urandom_range(0, 1) == 1);
      end
      if (DUMMY_EN && l > 1 && len == n_addr) begin ab = 0; co = 1'b0; end
      run_txn(cmd, 8'($urandom), ab, co);
    end

    tick(10);
    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/qspi_sampler.md
Name: qspi_sampler

Overview:
- Next-generation SPI slave front end. Runs entirely in the system clock domain by oversampling spi_clk, spi_cs and spi_data, rather than clocking from spi_clk.
- Supports single, dual and quad lanes. The lane mode is selected per transaction by the command byte.
- Delivers received bytes as single-cycle strobes and shifts transmit bytes out MSB first on spi_clk falling edges.
- Sits between the flash pins and the spispy emulation/logging core. It removes the need for separate strobe-crossing logic.

Parameters:
- SYNC_STAGES, 2, number of input synchronizer flops on spi_clk, spi_cs and spi_data (minimum 2).
- DUAL_CMD, 8'h3B, command byte that selects dual-lane mode.
- QUAD_CMD, 8'hEB, command byte that selects quad-lane mode.
- ADDR_BYTES, 3, number of multi-lane address bytes following DUAL_CMD or QUAD_CMD.
- DUMMY_CLKS, 4, spi_clk cycles skipped after the address (only with QSPI_DUMMY_EN).
- COUNT_W, 16, width of byte_count.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge).
- spi_clk  in  1  raw SPI clock, asynchronous.
- spi_cs  in  1  raw chip select, active low, asynchronous.
- spi_data_in  in  4  raw IO lanes: [0]=MOSI/IO0, [1]=MISO/IO1, [3:2]=IO3:IO2.
- spi_data_out  out  4  output lane values.
- spi_data_oe  out  4  per-lane output enable.
- tx_byte  in  8  next byte to transmit.
- tx_load  in  1  latch tx_byte into the holding register.
- byte_rx  out  8  last received byte; valid when a strobe is high.
- cmd_strobe  out  1  one-clk pulse: command byte complete.
- byte_strobe  out  1  one-clk pulse: non-command byte complete.
- abort_strobe  out  1  one-clk pulse: CS rose with a partial byte pending.
- lane_mode  out  2  current mode: 0=single, 1=dual, 2=quad.
- byte_count  out  COUNT_W  bytes received since CS fell, including the command byte.

Behaviour:
- Reset values: all outputs 0, lane_mode=0, state IDLE, tx holding register 8'h00.
- Edge detection:
  - spi_clk, spi_cs and spi_data_in each pass through SYNC_STAGES flops.
  - rise/fall is detected by comparing the last sync stage with one further register.
  - Data lanes are sampled from the same delayed stage as the clock edge.
- Latency: a strobe asserts exactly SYNC_STAGES+1 clk cycles after the raw spi_clk rising edge that completes a byte.
- States: IDLE, CMD, ADDR, DUMMY, DATA.
- IDLE:
  - Entered whenever synced CS is high.
  - Bit counter cleared, lane_mode=0, oe=0.
  - Synced CS falling -> CMD, byte_count=0.
- CMD:
  - 8 rises sampled on lane 0, MSB first.
  - On the 8th rise: byte_rx=command, cmd_strobe pulses, byte_count increments.
  - If command==QUAD_CMD: lane_mode=2, -> ADDR.
  - If command==DUAL_CMD: lane_mode=1, -> ADDR.
  - Otherwise: -> DATA in single mode.
- Bits per rise: 1, 2 or 4 per lane_mode. Lanes are shifted in with the high lane first, MSB first. A byte completes after 8, 4 or 2 rises respectively.
- ADDR: after ADDR_BYTES bytes (each raising byte_strobe) -> DUMMY if the feature is enabled, else -> DATA.
- DATA: every completed byte raises byte_strobe. Remains in DATA until CS rises.
- Transmit path:
  - On the first spi_clk fall of each byte period, the shift register loads the tx holding register.
  - Subsequent falls shift out 1, 2 or 4 bits.
  - Single mode: drives lane 1 only, oe=4'b0010 throughout CMD and DATA.
  - Dual/quad: oe=0 during ADDR/DUMMY; oe=4'b0011 or 4'b1111 in DATA.
- tx_load:
  - When high, tx_byte is written to the holding register that cycle.
  - If not reloaded, the previous value repeats.
  - A load in the same clk as a shift-register load is visible to that load.
- byte_count saturates at all-ones; no wrap.
- CS rising while bits are pending:
  - Partial byte discarded, no byte strobe, abort_strobe pulses.
  - A CS rise on the same synced cycle as a completing rise takes priority: no strobe, abort pulses.
- reset low mid-transaction: immediate return to IDLE. The current transaction is ignored until CS is seen high, then falls again.

Optional Feature:
- Macro QSPI_DUMMY_EN.
- Defined: DUMMY state counts DUMMY_CLKS rises, then -> DATA. No strobes and oe=0 during the count. Rises during DUMMY do not affect byte_rx.
- Undefined: the DUMMY state and its counter are not built, and ADDR goes directly to DATA.

Test Plan:
- Single 03 A5 5A 01 02, CS rise -> cmd_strobe with 03, byte_strobes A5,5A,01,02; byte_count=5; lane_mode=0; no abort.
- Quad EB then 10 20 30 40 in 2 nibbles each -> cmd EB, lane_mode=2, strobes 10,20,30 (addr), 40 (data); oe=0 during addr and 4'hF in data.
- Dual 3B then A5 via 4 rises of 2 bits -> lane_mode=1, byte_rx=A5.
- QSPI_DUMMY_EN with DUMMY_CLKS=4: EB + 3 addr + 4 dummy rises + byte 7E -> exactly one data strobe, value 7E; tx_byte C3 loaded appears on lanes 3:0 as C then 3.
- CS rises after 5 bits of the second byte -> abort_strobe pulse, no byte_strobe, next transaction starts cleanly with cmd_strobe.
- Timing check: strobe at exactly SYNC_STAGES+1 clk after the completing raw rise, for SYNC_STAGES=2 and 3.
